// File: rtl/param_stack.sv
// param_stack: LIFO used as the return-address stack and the operand/scratch stack.
// Storage is a circular buffer: wr_ptr points at the next free slot and count
// holds the occupancy. A push into a full stack either overwrites the oldest
// entry (OVERWRITE=1) or is dropped (OVERWRITE=0). Either case raises a
// one-cycle overflow pulse.
module param_stack #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 16,
    parameter bit OVERWRITE = 1'b1,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;

    // Next-state decode
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    ptr_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    // Pointer neighbours. The wrap is explicit so DEPTH need not be a power of two.
    always_comb begin
        top_idx = (wr_ptr == '0) ? LAST_IDX : wr_ptr - PW'(1);
        ptr_inc = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
        ptr_dec = top_idx;
    end

    // Status outputs come straight from registered state.
    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_MAX);
        top   = empty ? '0 : mem[top_idx];
    end

    // Decode the operation for this cycle in priority order.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = wr_ptr;
        ptr_nxt = wr_ptr;
        cnt_nxt = count;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (clear) begin
            ptr_nxt = '0;
            cnt_nxt = '0;
        end else if (push && pop && !empty) begin
            // Replace the top in place. This never overflows, even when full.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push && !full) begin
            // A plain push, or push+pop on an empty stack, which acts as a push.
            wr_en   = 1'b1;
            ptr_nxt = ptr_inc;
            cnt_nxt = count + CW'(1);
        end else if (push) begin
            // Full: the slot at wr_ptr holds the oldest entry.
            ovf_nxt = 1'b1;
            if (OVERWRITE) begin
                wr_en   = 1'b1;
                ptr_nxt = ptr_inc;
            end
        end else if (pop) begin
            if (!empty) begin
                ptr_nxt = ptr_dec;
                cnt_nxt = count - CW'(1);
            end else begin
                unf_nxt = 1'b1;
            end
        end
    end

    // Pointer, occupancy and the one-cycle error flags.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= ptr_nxt;
            count     <= cnt_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

    // Storage write. Reset zeroes every entry. Pop and clear leave the data in place.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= data_in;
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: runs two stacks (overwrite and reject policy) side by side
// on the same stimulus. A shift-array reference model predicts the outputs of
// both each cycle. It pushes the predictions to a scoreboard, and the bench
// pops them after the clock edge.
module tb_param_stack;

    localparam int D = 4;
    localparam int W = 16;

    logic          clock;
    logic          reset_L;
    logic          clear;
    logic          push;
    logic          pop;
    logic [W-1:0]  data_in;

    logic [W-1:0]  top0, top1;
    logic [2:0]    count0, count1;
    logic          empty0, empty1, full0, full1;
    logic          ovf0, ovf1, unf0, unf1;

    param_stack #(.DEPTH(D), .WIDTH(W), .OVERWRITE(1'b1)) dut_ow (
        .clock(clock), .reset_L(reset_L), .clear(clear), .push(push), .pop(pop),
        .data_in(data_in), .top(top0), .count(count0), .empty(empty0), .full(full0),
        .overflow(ovf0), .underflow(unf0)
    );

    param_stack #(.DEPTH(D), .WIDTH(W), .OVERWRITE(1'b0)) dut_rj (
        .clock(clock), .reset_L(reset_L), .clear(clear), .push(push), .pop(pop),
        .data_in(data_in), .top(top1), .count(count1), .empty(empty1), .full(full1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] top;
        int           cnt;
        bit           emp;
        bit           ful;
        bit           ovf;
        bit           unf;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_data [2][D];
    int           m_cnt [2];
    int           errs;
    int           checks;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: index 0 is the oldest entry, m_cnt-1 is the top; k=0 overwrites, k=1 rejects.
    task automatic model(input int k, input bit p, input bit po, input bit c, input logic [W-1:0] d);
        exp_t e;
        bit   ov = 1'b0;
        bit   un = 1'b0;
        if (c) begin
            m_cnt[k] = 0;
        end else if (p && po && m_cnt[k] > 0) begin
            m_data[k][m_cnt[k]-1] = d;
        end else if (p && m_cnt[k] < D) begin
            m_data[k][m_cnt[k]] = d;
            m_cnt[k]++;
        end else if (p) begin
            ov = 1'b1;
            if (k == 0) begin
                for (int i = 0; i < D - 1; i++) m_data[k][i] = m_data[k][i+1];
                m_data[k][D-1] = d;
            end
        end else if (po) begin
            if (m_cnt[k] > 0) m_cnt[k]--;
            else un = 1'b1;
        end
        e.top = (m_cnt[k] > 0) ? m_data[k][m_cnt[k]-1] : '0;
        e.cnt = m_cnt[k];
        e.emp = (m_cnt[k] == 0);
        e.ful = (m_cnt[k] == D);
        e.ovf = ov;
        e.unf = un;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [W-1:0] t, input logic [2:0] c,
                       input logic em, input logic fu, input logic ov, input logic un);
        chk({nm, ".top"},  32'(t),  32'(e.top));
        chk({nm, ".cnt"},  32'(c),  32'(e.cnt));
        chk({nm, ".emp"},  32'(em), 32'(e.emp));
        chk({nm, ".full"}, 32'(fu), 32'(e.ful));
        chk({nm, ".ovf"},  32'(ov), 32'(e.ovf));
        chk({nm, ".unf"},  32'(un), 32'(e.unf));
    endtask

    // One clock of stimulus. Outputs are sampled 1 ns after the edge.
    task automatic step(input bit p, input bit po, input bit c, input logic [W-1:0] d);
        exp_t e;
        push = p; pop = po; clear = c; data_in = d;
        model(0, p, po, c, d);
        model(1, p, po, c, d);
        @(posedge clock);
        #1;
        push = 1'b0; pop = 1'b0; clear = 1'b0;
        e = sb.pop_front();
        cmp("ow", e, top0, count0, empty0, full0, ovf0, unf0);
        e = sb.pop_front();
        cmp("rj", e, top1, count1, empty1, full1, ovf1, unf1);
    endtask

    initial begin
        errs = 0; checks = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        reset_L = 1'b0;
        #1;
        chk("rst.top",   32'(top0),   32'h0);
        chk("rst.cnt",   32'(count0), 32'h0);
        chk("rst.empty", 32'(empty0), 32'h1);
        chk("rst.full",  32'(full1),  32'h0);
        chk("rst.flags", 32'({ovf0, unf0, ovf1, unf1}), 32'h0);
        @(negedge clock);
        reset_L = 1'b1;

        // Basic push three, pop three.
        step(1, 0, 0, 16'h1111);
        step(1, 0, 0, 16'h2222);
        step(1, 0, 0, 16'h3333);
        chk("tp.top3", 32'(top0), 32'h3333);
        chk("tp.cnt3", 32'(count1), 32'h3);
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        chk("tp.empty", 32'(empty0), 32'h1);

        // Underflow on empty, then recovery.
        step(0, 1, 0, '0);
        chk("tp.unf", 32'(unf0), 32'h1);
        step(0, 0, 0, '0);
        step(1, 0, 0, 16'h00AA);
        chk("tp.aa", 32'(top1), 32'h00AA);
        step(0, 1, 0, '0);

        // Five pushes into a depth-4 stack. The two policies diverge here.
        for (int i = 1; i <= 5; i++) step(1, 0, 0, W'(i));
        chk("tp.ovf_ow", 32'(ovf0), 32'h1);
        chk("tp.ovf_rj", 32'(ovf1), 32'h1);
        step(0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
        chk("tp.drain", 32'({empty0, empty1}), 32'h3);

        // Push+pop replaces the top entry. On an empty stack it acts as a push.
        step(1, 0, 0, 16'h0001);
        step(1, 0, 0, 16'h0002);
        step(1, 1, 0, 16'h00FF);
        chk("tp.repl", 32'(top0), 32'h00FF);
        step(0, 1, 0, '0);
        chk("tp.after", 32'(top0), 32'h0001);
        step(0, 1, 0, '0);
        step(1, 1, 0, 16'h0033);
        chk("tp.pp_empty", 32'({count0, unf0}), 32'({3'd1, 1'b0}));

        // Push+pop while full replaces the top and raises no overflow.
        step(1, 0, 0, 16'h0044);
        step(1, 0, 0, 16'h0055);
        step(1, 0, 0, 16'h0066);
        step(1, 1, 0, 16'h0077);

        // Clear wins over push.
        step(1, 0, 1, 16'hBEEF);
        chk("tp.clear", 32'(count1), 32'h0);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), W'($urandom));

        // An asynchronous reset in mid-cycle takes effect with no clock edge.
        step(1, 0, 0, 16'h0101);
        step(1, 0, 0, 16'h0202);
        step(1, 0, 0, 16'h0303);
        push = 1'b1; data_in = 16'h0404;
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst.cnt0",  32'(count0), 32'h0);
        chk("arst.cnt1",  32'(count1), 32'h0);
        chk("arst.empty", 32'({empty0, empty1}), 32'h3);
        chk("arst.top",   32'(top0), 32'h0);
        push = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        @(negedge clock);
        reset_L = 1'b1;
        step(1, 0, 0, 16'h0505);
        step(0, 1, 0, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
